// File: rtl/pstretch.sv
// pstretch: pulse-to-level converter.
// A one-clock trigger on `in` produces a level on `l` that rises DELAY clocks
// after the sampling edge and stays high for WIDTH clocks. A one-clock pulse
// on `p` marks the falling edge of the level. A trigger that arrives while a
// sequence is running either restarts it (RETRIG=1) or is dropped and sets the
// sticky `ovr` flag (RETRIG=0). `clr` aborts everything and clears `ovr`.
module pstretch #(
  parameter int DELAY  = 0,   // clocks from trigger edge to level rise, 0..1023
  parameter int WIDTH  = 10,  // clocks the level stays high, 1..1023
  parameter int RETRIG = 0    // 1: retrigger restarts, 0: retrigger ignored + flagged
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  input  logic clr,
  output logic l,
  output logic p,
  output logic busy,
  output logic ovr
);

  // The counter only ever holds DELAY-1 or WIDTH-1, so max(DELAY, WIDTH) bits
  // of range is always enough.
  localparam int MAX_LEN = (DELAY > WIDTH) ? DELAY : WIDTH;
  localparam int CW      = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  // Where a fresh sequence begins: a zero delay skips straight to the level.
  localparam int       DLY_LOAD_I  = (DELAY > 0) ? DELAY - 1 : 0;
  localparam int       WID_LOAD_I  = (WIDTH > 0) ? WIDTH - 1 : 0;
  localparam logic [CW-1:0] DLY_LOAD = CW'(DLY_LOAD_I);
  localparam logic [CW-1:0] WID_LOAD = CW'(WID_LOAD_I);
  localparam state_t   START_STATE = (DELAY > 0) ? S_DELAY : S_ACTIVE;
  localparam logic [CW-1:0] START_CNT = (DELAY > 0) ? DLY_LOAD : WID_LOAD;
  localparam logic     START_L     = (DELAY > 0) ? 1'b0 : 1'b1;
  localparam logic     RETRIG_EN   = (RETRIG != 0);

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          l_q;
  logic          p_q;
  logic          busy_q;
  logic          ovr_q;

  // Sequencer: state, down-counter and all registered outputs in one place.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      l_q     <= 1'b0;
      p_q     <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      // The trailing-edge pulse lasts exactly one cycle unless re-armed below.
      p_q <= 1'b0;
      if (clr) begin
        // Abort wins over any trigger on the same edge; no trailing pulse.
        state_q <= S_IDLE;
        cnt_q   <= '0;
        l_q     <= 1'b0;
        busy_q  <= 1'b0;
        ovr_q   <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (in) begin
              state_q <= START_STATE;
              cnt_q   <= START_CNT;
              l_q     <= START_L;
              busy_q  <= 1'b1;
            end
          end

          S_DELAY: begin
            if (in && RETRIG_EN) begin
              // Restart: we are already in the delay phase, just reload.
              state_q <= START_STATE;
              cnt_q   <= START_CNT;
              l_q     <= START_L;
            end else begin
              if (in) begin
                ovr_q <= 1'b1;
              end
              if (cnt_q == '0) begin
                state_q <= S_ACTIVE;
                cnt_q   <= WID_LOAD;
                l_q     <= 1'b1;
              end else begin
                cnt_q <= cnt_q - 1'b1;
              end
            end
          end

          S_ACTIVE: begin
            if (cnt_q == '0) begin
              // Final edge of the level: always pulse, and a trigger on this
              // very edge is a legal back-to-back start, never an overrun.
              p_q <= 1'b1;
              if (in) begin
                state_q <= START_STATE;
                cnt_q   <= START_CNT;
                l_q     <= START_L;
                busy_q  <= 1'b1;
              end else begin
                state_q <= S_IDLE;
                l_q     <= 1'b0;
                busy_q  <= 1'b0;
              end
            end else if (in && RETRIG_EN) begin
              // Mid-level restart: level drops only if a delay phase follows.
              state_q <= START_STATE;
              cnt_q   <= START_CNT;
              l_q     <= START_L;
            end else begin
              if (in) begin
                ovr_q <= 1'b1;
              end
              cnt_q <= cnt_q - 1'b1;
            end
          end

          default: begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            l_q     <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign l    = l_q;
  assign p    = p_q;
  assign busy = busy_q;
  assign ovr  = ovr_q;

endmodule

// File: tb/tb_pstretch.sv
// tb_pstretch: randomized scoreboard bench for pstretch.
// Three instances with different DELAY/WIDTH/RETRIG share the same trigger,
// abort and reset stimulus. The reference model tracks only the edge number
// at which the current sequence started and derives every output from the
// elapsed edge count; expectations are queued and checked by a monitor.
module tb_pstretch;

  localparam int N    = 3;
  localparam int DLY [N] = '{3, 0, 2};
  localparam int WID [N] = '{4, 5, 6};
  localparam int RTG [N] = '{0, 1, 1};
  localparam int NONE = -1000000;
  localparam int CYCLES = 4000;

  logic clk = 1'b0;
  logic reset;
  logic in_s;
  logic clr;
  logic [N-1:0] l_w;
  logic [N-1:0] p_w;
  logic [N-1:0] busy_w;
  logic [N-1:0] ovr_w;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_dut
      pstretch #(
        .DELAY (DLY[gi]),
        .WIDTH (WID[gi]),
        .RETRIG(RTG[gi])
      ) u_dut (
        .clk  (clk),
        .reset(reset),
        .in   (in_s),
        .clr  (clr),
        .l    (l_w[gi]),
        .p    (p_w[gi]),
        .busy (busy_w[gi]),
        .ovr  (ovr_w[gi])
      );
    end
  endgenerate

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model state: start edge of live sequence (NONE if idle) and sticky flag.
  int t0    [N];
  bit ovr_m [N];

  // Expected outputs per edge, 4 bits per instance: {l, p, busy, ovr}.
  logic [4*N-1:0] sb [$];

  task automatic check(input string name, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d edge=%0d got=%b want=%b", name, idx, cyc, act, exp);
    end
  endtask

  // Evaluate the model for the rising edge just taken and queue the result.
  task automatic model_step();
    logic [4*N-1:0] ent;
    ent = '0;
    for (int i = 0; i < N; i++) begin
      int  len;
      int  j;
      bit  live;
      bit  pe;
      bit  be;
      bit  le;
      len = DLY[i] + WID[i];
      pe  = 1'b0;
      if (reset || clr) begin
        t0[i]    = NONE;
        ovr_m[i] = 1'b0;
      end else begin
        j    = cyc - t0[i];
        live = (t0[i] != NONE) && (j < len);
        if (t0[i] != NONE && j == len) begin
          pe    = 1'b1;
          t0[i] = NONE;
        end
        if (in_s) begin
          if (!live || RTG[i] != 0) t0[i] = cyc;
          else                      ovr_m[i] = 1'b1;
        end
      end
      j  = cyc - t0[i];
      be = (t0[i] != NONE) && (j >= 0) && (j < len);
      le = be && (j >= DLY[i]);
      ent[4*i+3] = le;
      ent[4*i+2] = pe;
      ent[4*i+1] = be;
      ent[4*i+0] = ovr_m[i];
    end
    sb.push_back(ent);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
  endtask

  // Monitor: compare every queued expectation against the sampled outputs.
  initial begin
    logic [4*N-1:0] e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        for (int i = 0; i < N; i++) begin
          check("l",    i, l_w[i],    e[4*i+3]);
          check("p",    i, p_w[i],    e[4*i+2]);
          check("busy", i, busy_w[i], e[4*i+1]);
          check("ovr",  i, ovr_w[i],  e[4*i+0]);
        end
      end
    end
  end

  // Stimulus: random triggers, rare aborts and rare asynchronous resets.
  initial begin
    int in_div;
    for (int i = 0; i < N; i++) begin
      t0[i]    = NONE;
      ovr_m[i] = 1'b0;
    end
    reset = 1'b1;
    in_s  = 1'b0;
    clr   = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    for (int n = 0; n < CYCLES; n++) begin
      // Alternate sparse phases (full sequences) with dense ones (retriggers).
      in_div = ((n / 500) % 2 == 0) ? 12 : 3;
      in_s   = ($urandom_range(0, in_div - 1) == 0);
      clr    = ($urandom_range(0, 59) == 0);
      if (reset) begin
        reset = 1'b0;
      end else if ($urandom_range(0, 249) == 0) begin
        // Assert mid-cycle, away from any clock edge, and expect immediate clear.
        #2 reset = 1'b1;
        #1;
        for (int i = 0; i < N; i++) begin
          check("async_rst_l",    i, l_w[i],    1'b0);
          check("async_rst_p",    i, p_w[i],    1'b0);
          check("async_rst_busy", i, busy_w[i], 1'b0);
          check("async_rst_ovr",  i, ovr_w[i],  1'b0);
        end
      end
      tick();
    end

    reset = 1'b0;
    in_s  = 1'b0;
    clr   = 1'b0;
    repeat (20) tick();
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d want=0 pending entries", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pstretch.md
# pstretch

Pulse-to-level converter, the counterpart of the edge-to-pulse generators and pulse delay lines. It accepts a one-clock pulse and produces a level that rises a fixed number of clocks later and holds for a fixed width. At the level's trailing edge it emits a one-clock pulse. It models timed level signals (one-shot / flip-flop driven by a pulse) that feed pulse-sensitive logic elsewhere in the machine, with defined behaviour for retrigger, abort and overrun.

## Interface
- DELAY, 0, clocks from the trigger edge to level rise; range 0..1023.
- WIDTH, 10, clocks the level stays high; range 1..1023. 0 is illegal.
- RETRIG, 0, 1 means a trigger while busy restarts the sequence; 0 means it is ignored and flagged.
- clk  in  1  single system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in  in  1  trigger pulse; sampled each rising edge; nominally one clock wide.
- clr  in  1  abort pulse; returns the block to idle and clears ovr.
- l  out  1  stretched level, registered.
- p  out  1  one-clock trailing-edge pulse, registered.
- busy  out  1  high in DELAY or ACTIVE.
- ovr  out  1  sticky overrun flag, set when a trigger is ignored.

## Operation
- States:
  - IDLE (l=0, busy=0)
  - DELAY (l=0, busy=1)
  - ACTIVE (l=1, busy=1)
- One down-counter, sized to hold max(DELAY, WIDTH).
- IDLE, in=1:
  - DELAY>0: go to DELAY, counter=DELAY-1.
  - DELAY=0: go to ACTIVE, counter=WIDTH-1.
- DELAY: decrement each clock. At counter 0, go to ACTIVE with counter=WIDTH-1.
- ACTIVE: decrement each clock. At counter 0:
  - assert p for the next cycle;
  - go to IDLE, or start a new sequence if in=1 on that same edge.
- in=1 while busy, excluding the final ACTIVE edge:
  - RETRIG=1: restart as if from IDLE. l drops if DELAY>0 and stays high if DELAY=0. No p is emitted.
  - RETRIG=0: ignore the trigger and set ovr=1.
- clr=1: go to IDLE, l=0, ovr=0, no p. clr beats a simultaneous in, which is dropped.
- ovr is cleared only by clr or reset.
- Reset values: state IDLE, counter 0, l=0, p=0, busy=0, ovr=0.
- in held high for several clocks: each high edge is a separate trigger.

## Timing
- Let t0 be the rising edge that samples in=1 from IDLE.
- Level: l is high from just after edge t0+DELAY until just after edge t0+DELAY+WIDTH, i.e. exactly WIDTH cycles.
- busy: high from just after t0 and drops together with l.
- p: high for exactly one cycle, starting just after edge t0+DELAY+WIDTH, which is the cycle l falls.
- Back-to-back trigger on the final ACTIVE edge:
  - p still fires.
  - DELAY=0: l stays high with no gap.
  - DELAY>0: l is low for DELAY cycles.
- reset asserted mid-sequence: outputs go low asynchronously. No p is emitted after release. The first trigger after release behaves like t0.
- Worst-case latency from in to l: DELAY+1 edges, counting the sampling edge.

## Test plan
- DELAY=0, WIDTH=10, in pulse at edge 5 -> l high for cycles 6..15, p high for cycle 16 only, busy tracks l, ovr=0.
- DELAY=3, WIDTH=4, in at edge 0, second in at edge 2, RETRIG=0 -> l high for cycles 4..7, p in cycle 8, ovr=1 from cycle 3 until clr.
- Same stimulus with RETRIG=1 -> l high for cycles 6..9, p in cycle 10, ovr stays 0.
- DELAY=0, WIDTH=5, in at edge 0 and again at edge 5 -> l continuously high for cycles 1..10, p in cycles 6 and 11.
- DELAY=2, WIDTH=6, in at edge 0, clr and in together at edge 4 -> l low from cycle 5, no p, ovr=0, block idle; a later trigger behaves normally.
- in at edge 0, reset pulse during ACTIVE -> l, p, busy and ovr go to 0 immediately; after release, a trigger at edge t gives l for cycles t+1..t+WIDTH.
